maple_frame_tx: RTL

//  Maple bus frame transmitter: byte-stream side to SDCKA/SDCKB line side.

---
 rtl/maple_frame_tx.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/maple_frame_tx.sv
// Maple bus frame transmitter: bytes in on valid/ready, start/bits/[checksum]/end/gap on SDCKA/SDCKB.
// Latency: in_valid in IDLE -> SDCKA falls 1 clk later; line levels change only on T_SLOT slot boundaries.
// Backpressure: in_ready is a one-cycle consume pulse; a missing byte at a byte boundary ends the frame (err_underrun).
// Optional feature: define MAPLE_CRC_EN to append the XOR checksum byte before the end pattern.
module maple_frame_tx #(
    parameter int T_SLOT    = 4,
    parameter int GAP_SLOTS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       sdcka_out,
    output logic       sdckb_out,
    output logic       busy,
    output logic       err_underrun
);

    localparam int TW = $clog2(T_SLOT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BITS,
        S_CRC,
        S_END,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [7:0]      slot_q, slot_d;    // slot index within START / END / GAP
    logic [2:0]      bit_q, bit_d;      // bit index being sent, 7 down to 0
    logic [1:0]      sub_q, sub_d;      // slot within the current bit, 0..2
    logic [7:0]      shift_q, shift_d;  // byte on the line
    logic            last_q, last_d;    // byte on the line closes the frame
`ifdef MAPLE_CRC_EN
    logic [7:0]      acc_q, acc_d;      // running XOR of data bytes
`endif

    logic slot_end;
    logic data_bit;

    assign slot_end = (tick_q == TW'(T_SLOT - 1));
    assign data_bit = shift_q[bit_q];
    assign busy     = (state_q != S_IDLE);

    // State and datapath registers; reset drops straight to IDLE with lines released
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            slot_q  <= '0;
            bit_q   <= 3'd7;
            sub_q   <= '0;
            shift_q <= '0;
            last_q  <= 1'b0;
`ifdef MAPLE_CRC_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            slot_q  <= slot_d;
            bit_q   <= bit_d;
            sub_q   <= sub_d;
            shift_q <= shift_d;
            last_q  <= last_d;
`ifdef MAPLE_CRC_EN
            acc_q   <= acc_d;
`endif
        end
    end

    // Next-state, slot sequencing, byte loading and handshake pulses
    always_comb begin
        state_d      = state_q;
        tick_d       = slot_end ? '0 : tick_q + 1'b1;
        slot_d       = slot_q;
        bit_d        = bit_q;
        sub_d        = sub_q;
        shift_d      = shift_q;
        last_d       = last_q;
`ifdef MAPLE_CRC_EN
        acc_d        = acc_q;
`endif
        in_ready     = 1'b0;
        err_underrun = 1'b0;

        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                // in_ready is gated by reset so a byte offered during reset is never acknowledged
                if (in_valid && !reset) begin
                    in_ready = 1'b1;
                    shift_d  = in_data;
                    last_d   = in_last;
`ifdef MAPLE_CRC_EN
                    acc_d    = '0;
`endif
                    slot_d   = '0;
                    state_d  = S_START;
                end
            end

            S_START: begin
                if (slot_end) begin
                    if (slot_q == 8'd8) begin
                        slot_d  = '0;
                        bit_d   = 3'd7;
                        sub_d   = '0;
                        state_d = S_BITS;
                    end else begin
                        slot_d = slot_q + 8'd1;
                    end
                end
            end

            S_BITS, S_CRC: begin
                if (slot_end) begin
                    if (sub_q != 2'd2) begin
                        sub_d = sub_q + 2'd1;
                    end else begin
                        sub_d = '0;
                        bit_d = bit_q - 3'd1;   // wraps 0 -> 7 for the next byte
                        if (bit_q == 3'd0) begin
                            slot_d = '0;
                            if (state_q == S_CRC) begin
                                state_d = S_END;
                            end else begin
`ifdef MAPLE_CRC_EN
                                acc_d = acc_q ^ shift_q;
`endif
                                if (!last_q) begin
                                    // the next byte must already be waiting in the final cycle
                                    if (in_valid) begin
                                        in_ready = 1'b1;
                                        shift_d  = in_data;
                                        last_d   = in_last;
                                    end else begin
                                        err_underrun = 1'b1;
                                        state_d      = S_END;
                                    end
                                end else begin
`ifdef MAPLE_CRC_EN
                                    shift_d = acc_q ^ shift_q;
                                    state_d = S_CRC;
`else
                                    state_d = S_END;
`endif
                                end
                            end
                        end
                    end
                end
            end

            S_END: begin
                if (slot_end) begin
                    if (slot_q == 8'd5) begin
                        slot_d  = '0;
                        state_d = S_GAP;
                    end else begin
                        slot_d = slot_q + 8'd1;
                    end
                end
            end

            S_GAP: begin
                if (slot_end) begin
                    if (slot_q == 8'(GAP_SLOTS - 1)) begin
                        slot_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        slot_d = slot_q + 8'd1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Line levels decoded from registered state only, so they move only on slot boundaries
    always_comb begin
        sdcka_out = 1'b1;
        sdckb_out = 1'b1;
        case (state_q)
            S_START: begin
                sdcka_out = 1'b0;
                sdckb_out = ~slot_q[0];
            end
            S_BITS, S_CRC: begin
                // bits 7,5,3,1 clock on A with data on B; bits 6,4,2,0 swap roles
                if (bit_q[0]) begin
                    sdcka_out = (sub_q != 2'd1);
                    sdckb_out = data_bit;
                end else begin
                    sdcka_out = data_bit;
                    sdckb_out = (sub_q != 2'd1);
                end
            end
            S_END: begin
                if (slot_q == 8'd5) begin
                    sdcka_out = 1'b1;
                    sdckb_out = 1'b1;
                end else begin
                    sdcka_out = ~slot_q[0];
                    sdckb_out = 1'b0;
                end
            end
            default: begin
                sdcka_out = 1'b1;
                sdckb_out = 1'b1;
            end
        endcase
    end

endmodule
